// File: rtl/matrix_accumulator.sv
// Lane-wise frame accumulator: sums LANES unsigned products per beat into ACC_W-bit lanes
// and holds the finished matrix on a valid/ready output. Define ACC_SATURATE_EN to clamp on overflow.
module matrix_accumulator #(
    parameter int LANES = 16,
    parameter int IN_W  = 32,
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*IN_W-1:0]    in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*ACC_W-1:0]   out_data,
    output logic [CNT_W-1:0]         out_count,
    output logic [LANES-1:0]         out_ovf
);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

`ifdef ACC_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // Beat index at which the frame is forced closed (its beat count becomes 2^CNT_W-1).
    localparam logic [CNT_W-1:0] CNT_FORCE = {{(CNT_W-1){1'b1}}, 1'b0};

    // raw carries the carry-out in its MSB; sticky keeps a saturated lane pinned.
    function automatic logic [ACC_W-1:0] lane_update(input logic [ACC_W:0] raw, input logic sticky);
        if (SAT_EN && (raw[ACC_W] || sticky))
            return {ACC_W{1'b1}};
        else
            return raw[ACC_W-1:0];
    endfunction

    logic [0:0]        state;
    logic [ACC_W-1:0]  acc_p0 [LANES];
    logic [LANES-1:0]  ovf_p0;
    logic [CNT_W-1:0]  count_p0;

    logic [ACC_W:0]    raw_p0 [LANES];
    logic [ACC_W-1:0]  sum_nxt [LANES];
    logic [LANES-1:0]  ovf_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              accept;
    logic              frame_end;

    assign in_ready  = (state == ACCUM);
    assign accept    = in_valid & in_ready;
    assign count_nxt = count_p0 + 1'b1;
    assign frame_end = accept & (in_last | (count_p0 == CNT_FORCE));

    // stage p0: lane sums with carry detection
    always_comb begin
        ovf_nxt = '0;
        for (int i = 0; i < LANES; i++) begin
            raw_p0[i]  = {1'b0, acc_p0[i]}
                       + {{(ACC_W+1-IN_W){1'b0}}, in_data[i*IN_W +: IN_W]};
            sum_nxt[i] = lane_update(raw_p0[i], ovf_p0[i]);
            ovf_nxt[i] = ovf_p0[i] | raw_p0[i][ACC_W];
        end
    end

    // stage p1: accumulator state and registered output frame
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ACCUM;
            count_p0  <= '0;
            ovf_p0    <= '0;
            for (int i = 0; i < LANES; i++)
                acc_p0[i] <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        for (int i = 0; i < LANES; i++)
                            acc_p0[i] <= sum_nxt[i];
                        count_p0 <= count_nxt;
                        ovf_p0   <= ovf_nxt;
                        if (frame_end) begin
                            for (int i = 0; i < LANES; i++)
                                out_data[i*ACC_W +: ACC_W] <= sum_nxt[i];
                            out_count <= count_nxt;
                            out_ovf   <= ovf_nxt;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        count_p0  <= '0;
                        ovf_p0    <= '0;
                        for (int i = 0; i < LANES; i++)
                            acc_p0[i] <= '0;
                        state     <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
